id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
Decode/execute pipeline register that sits directly downstream of the instruction-fetch buffer and register file, and upstream of the ALU, data memory and branch logic.
- Captures decoded operands, destination and control bits once per cycle.
- Detects load-use hazards, inserts one bubble and tells fetch/decode to hold.
- Applies write-back bypass at capture time and honours flush/hold requests.

Parameters:
WIDTH, 32, datapath width (PC, operands, immediate)
AW, 5, register address width
OPW, 6, ALU opcode width

Ports:
clock  in  1  system clock (gated core clock), all state on rising edge
reset  in  1  synchronous, active-low reset
flush  in  1  branch/jump taken; kill instruction being captured
hold_in  in  1  freeze this stage (memory wait / debug)
id_pc  in  WIDTH  PC of decoding instruction
id_rdata1  in  WIDTH  register file port 1 ([25:21])
id_rdata2  in  WIDTH  register file port 2 ([20:16])
id_imm  in  WIDTH  extended immediate
id_rs  in  AW  instr[25:21]
id_rt  in  AW  instr[20:16]
id_waddr  in  AW  selected destination register
id_reg_write, id_mem_to_reg, id_mem_write, id_mem_read, id_alu_src, id_branch, id_eq, id_goto  in  1 each  decoded control
id_alu_ctrl  in  OPW  ALU opcode
wb_reg_write  in  1  write-back enable this cycle
wb_waddr  in  AW  write-back register
wb_wdata  in  WIDTH  write-back data
hazard_stall  out  1  combinational; fetch/decode must hold PC and IF buffer
ex_valid  out  1  stage holds a real instruction
ex_pc, ex_rdata1, ex_rdata2, ex_imm  out  WIDTH  registered copies
ex_rs, ex_rt, ex_waddr  out  AW  registered copies
ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_mem_read, ex_alu_src, ex_branch, ex_eq, ex_goto  out  1 each  registered control
ex_alu_ctrl  out  OPW  registered opcode
bubble_count  out  16  load-use bubbles inserted

Behaviour:
- reset==0 at rising edge: every ex_* output, ex_valid and bubble_count go to 0. Reset wins over all other inputs, including mid-stall.
- uses_rt = ~id_alu_src | id_mem_write | id_branch.
- hazard_stall = ex_valid & ex_mem_read & (ex_waddr!=0) & ((ex_waddr==id_rs) | (uses_rt & ex_waddr==id_rt)).
  - Purely combinational from registered state and id_* inputs.
  - Forced to 0 while flush=1.
- Per-edge priority is reset > flush > hold_in > hazard_stall > normal capture.
- flush: all control outputs and ex_valid cleared to 0; data fields captured normally.
- hold_in=1 (no flush): all registers keep value; bubble_count unchanged. hazard_stall is still driven.
- hazard_stall=1: a bubble is inserted.
  - Controls and ex_valid are cleared.
  - bubble_count increments, saturating at 16'hFFFF.
  - The next cycle sees ex_mem_read=0, so exactly one bubble is inserted per load-use.
- Normal capture: all id_* fields are registered; ex_valid=1.
- Write-back bypass on capture:
  - If wb_reg_write & wb_waddr!=0 & wb_waddr==id_rs, ex_rdata1 takes wb_wdata; same rule for id_rt into ex_rdata2.
  - Both operands may bypass on the same edge.
- Register 0 is never a hazard or bypass source.
- Latency: one cycle from id_* to ex_*.
- No combinational path from id_* to ex_*.

Test Plan:
- Reset: drive reset=0 for 2 edges with all id_* = 1s -> all ex_* outputs, ex_valid and bubble_count are 0; after release, first capture has ex_valid=1.
- Normal capture: id_pc=0x10, id_rdata1=5, id_rdata2=7, id_reg_write=1, id_alu_ctrl=6'h20, id_waddr=3 -> next edge ex_pc=0x10, ex_rdata1=5, ex_rdata2=7, ex_reg_write=1, ex_alu_ctrl=0x20, ex_waddr=3.
- Load-use: lw to $8 in EX (ex_mem_read=1, ex_waddr=8), then R-type with id_rt=8 -> hazard_stall=1.
  - Next edge: ex_valid=0, all controls 0, bubble_count=1, hazard_stall=0.
  - The following edge captures the R-type.
- No false hazard: lw to $0, or id_alu_src=1 addi using rt=8 against lw $8 -> hazard_stall=0, no bubble.
- WB bypass: wb_reg_write=1, wb_waddr=4, wb_wdata=0xDEAD, id_rs=id_rt=4, id_rdata1=id_rdata2=0 -> ex_rdata1=ex_rdata2=0xDEAD.
  - Same stimulus with wb_waddr=0 -> both 0.
- Flush vs hold vs stall: flush=1, hold_in=1 and a hazard condition together -> hazard_stall=0, controls cleared, bubble_count unchanged.
  - hold_in=1 alone for 3 edges -> outputs frozen.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode/execute pipeline register.
// Captures decoded operands and control once per cycle. Detects load-use
// hazards and inserts a single bubble. Applies write-back bypass at capture
// time, and honours flush and hold requests.
module id_ex_stage #(
    parameter int WIDTH = 32,
    parameter int AW    = 5,
    parameter int OPW   = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             hold_in,
    input  logic [WIDTH-1:0] id_pc,
    input  logic [WIDTH-1:0] id_rdata1,
    input  logic [WIDTH-1:0] id_rdata2,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [AW-1:0]    id_rs,
    input  logic [AW-1:0]    id_rt,
    input  logic [AW-1:0]    id_waddr,
    input  logic             id_reg_write,
    input  logic             id_mem_to_reg,
    input  logic             id_mem_write,
    input  logic             id_mem_read,
    input  logic             id_alu_src,
    input  logic             id_branch,
    input  logic             id_eq,
    input  logic             id_goto,
    input  logic [OPW-1:0]   id_alu_ctrl,
    input  logic             wb_reg_write,
    input  logic [AW-1:0]    wb_waddr,
    input  logic [WIDTH-1:0] wb_wdata,
    output logic             hazard_stall,
    output logic             ex_valid,
    output logic [WIDTH-1:0] ex_pc,
    output logic [WIDTH-1:0] ex_rdata1,
    output logic [WIDTH-1:0] ex_rdata2,
    output logic [WIDTH-1:0] ex_imm,
    output logic [AW-1:0]    ex_rs,
    output logic [AW-1:0]    ex_rt,
    output logic [AW-1:0]    ex_waddr,
    output logic             ex_reg_write,
    output logic             ex_mem_to_reg,
    output logic             ex_mem_write,
    output logic             ex_mem_read,
    output logic             ex_alu_src,
    output logic             ex_branch,
    output logic             ex_eq,
    output logic             ex_goto,
    output logic [OPW-1:0]   ex_alu_ctrl,
    output logic [15:0]      bubble_count
);

    // Decoded control bits travel together so they can be cleared as a unit.
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_write;
        logic mem_read;
        logic alu_src;
        logic branch;
        logic eq;
        logic goto_;
    } ctrl_t;

    // Registered state.
    logic             valid_q,  valid_d;
    logic [WIDTH-1:0] pc_q,     pc_d;
    logic [WIDTH-1:0] rdata1_q, rdata1_d;
    logic [WIDTH-1:0] rdata2_q, rdata2_d;
    logic [WIDTH-1:0] imm_q,    imm_d;
    logic [AW-1:0]    rs_q,     rs_d;
    logic [AW-1:0]    rt_q,     rt_d;
    logic [AW-1:0]    waddr_q,  waddr_d;
    ctrl_t            ctrl_q,   ctrl_d;
    logic [OPW-1:0]   alu_q,    alu_d;
    logic [15:0]      bubble_q, bubble_d;

    // Combinational helpers.
    ctrl_t            id_ctrl;
    logic             uses_rt;
    logic             rs_match;
    logic             rt_match;
    logic             load_in_ex;
    logic             byp_rs;
    logic             byp_rt;
    logic [WIDTH-1:0] op1_byp;
    logic [WIDTH-1:0] op2_byp;

    // Bundle the decoded control inputs.
    always_comb begin
        id_ctrl            = '0;
        id_ctrl.reg_write  = id_reg_write;
        id_ctrl.mem_to_reg = id_mem_to_reg;
        id_ctrl.mem_write  = id_mem_write;
        id_ctrl.mem_read   = id_mem_read;
        id_ctrl.alu_src    = id_alu_src;
        id_ctrl.branch     = id_branch;
        id_ctrl.eq         = id_eq;
        id_ctrl.goto_      = id_goto;
    end

    // Load-use detection against the load currently held in EX; register 0 never counts.
    always_comb begin
        uses_rt      = ~id_alu_src | id_mem_write | id_branch;
        load_in_ex   = valid_q & ctrl_q.mem_read & (waddr_q != '0);
        rs_match     = (waddr_q == id_rs);
        rt_match     = uses_rt & (waddr_q == id_rt);
        hazard_stall = ~flush & load_in_ex & (rs_match | rt_match);
    end

    // Write-back bypass on the operands being captured; register 0 never forwards.
    always_comb begin
        byp_rs  = wb_reg_write & (wb_waddr != '0) & (wb_waddr == id_rs);
        byp_rt  = wb_reg_write & (wb_waddr != '0) & (wb_waddr == id_rt);
        op1_byp = byp_rs ? wb_wdata : id_rdata1;
        op2_byp = byp_rt ? wb_wdata : id_rdata2;
    end

    // Next-state selection: flush > hold > load-use bubble > normal capture.
    always_comb begin
        valid_d  = valid_q;
        pc_d     = pc_q;
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        imm_d    = imm_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        waddr_d  = waddr_q;
        ctrl_d   = ctrl_q;
        alu_d    = alu_q;
        bubble_d = bubble_q;

        if (flush) begin
            // Data still flows so downstream sees a consistent record; only control dies.
            pc_d     = id_pc;
            rdata1_d = op1_byp;
            rdata2_d = op2_byp;
            imm_d    = id_imm;
            rs_d     = id_rs;
            rt_d     = id_rt;
            waddr_d  = id_waddr;
            alu_d    = id_alu_ctrl;
            ctrl_d   = '0;
            valid_d  = 1'b0;
        end else if (hold_in) begin
            // Everything keeps its value.
            valid_d  = valid_q;
        end else if (hazard_stall) begin
            // Bubble: the load leaves EX, so the next cycle no longer matches.
            pc_d     = id_pc;
            rdata1_d = op1_byp;
            rdata2_d = op2_byp;
            imm_d    = id_imm;
            rs_d     = id_rs;
            rt_d     = id_rt;
            waddr_d  = id_waddr;
            alu_d    = id_alu_ctrl;
            ctrl_d   = '0;
            valid_d  = 1'b0;
            bubble_d = (bubble_q == 16'hFFFF) ? bubble_q : bubble_q + 16'd1;
        end else begin
            pc_d     = id_pc;
            rdata1_d = op1_byp;
            rdata2_d = op2_byp;
            imm_d    = id_imm;
            rs_d     = id_rs;
            rt_d     = id_rt;
            waddr_d  = id_waddr;
            alu_d    = id_alu_ctrl;
            ctrl_d   = id_ctrl;
            valid_d  = 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            imm_q    <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            waddr_q  <= '0;
            ctrl_q   <= '0;
            alu_q    <= '0;
            bubble_q <= '0;
        end else begin
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            imm_q    <= imm_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            waddr_q  <= waddr_d;
            ctrl_q   <= ctrl_d;
            alu_q    <= alu_d;
            bubble_q <= bubble_d;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_pc         = pc_q;
    assign ex_rdata1     = rdata1_q;
    assign ex_rdata2     = rdata2_q;
    assign ex_imm        = imm_q;
    assign ex_rs         = rs_q;
    assign ex_rt         = rt_q;
    assign ex_waddr      = waddr_q;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_alu_src    = ctrl_q.alu_src;
    assign ex_branch     = ctrl_q.branch;
    assign ex_eq         = ctrl_q.eq;
    assign ex_goto       = ctrl_q.goto_;
    assign ex_alu_ctrl   = alu_q;
    assign bubble_count  = bubble_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed stimulus, a record-level reference model checked
// every cycle, and hand-computed literal expectations.
module tb_id_ex_stage;

    localparam int W   = 32;
    localparam int AW  = 5;
    localparam int OPW = 6;

    logic           clock = 1'b0;
    logic           reset, flush, hold_in;
    logic [W-1:0]   id_pc, id_rdata1, id_rdata2, id_imm;
    logic [AW-1:0]  id_rs, id_rt, id_waddr;
    logic           id_reg_write, id_mem_to_reg, id_mem_write, id_mem_read;
    logic           id_alu_src, id_branch, id_eq, id_goto;
    logic [OPW-1:0] id_alu_ctrl;
    logic           wb_reg_write;
    logic [AW-1:0]  wb_waddr;
    logic [W-1:0]   wb_wdata;
    logic           hazard_stall, ex_valid;
    logic [W-1:0]   ex_pc, ex_rdata1, ex_rdata2, ex_imm;
    logic [AW-1:0]  ex_rs, ex_rt, ex_waddr;
    logic           ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_mem_read;
    logic           ex_alu_src, ex_branch, ex_eq, ex_goto;
    logic [OPW-1:0] ex_alu_ctrl;
    logic [15:0]    bubble_count;

    int tests  = 0;
    int failed = 0;
    bit chk_en = 1'b0;

    id_ex_stage #(.WIDTH(W), .AW(AW), .OPW(OPW)) dut (
        .clock(clock), .reset(reset), .flush(flush), .hold_in(hold_in),
        .id_pc(id_pc), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_waddr(id_waddr),
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
        .id_mem_write(id_mem_write), .id_mem_read(id_mem_read),
        .id_alu_src(id_alu_src), .id_branch(id_branch), .id_eq(id_eq), .id_goto(id_goto),
        .id_alu_ctrl(id_alu_ctrl),
        .wb_reg_write(wb_reg_write), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .hazard_stall(hazard_stall), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_waddr(ex_waddr),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_mem_write(ex_mem_write), .ex_mem_read(ex_mem_read),
        .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_eq(ex_eq), .ex_goto(ex_goto),
        .ex_alu_ctrl(ex_alu_ctrl), .bubble_count(bubble_count)
    );

    always #5 clock = ~clock;

    // Reference model: one instruction record in EX plus a bubble counter.
    typedef struct packed {
        logic           valid;
        logic [W-1:0]   pc, r1, r2, imm;
        logic [AW-1:0]  rs, rt, wa;
        logic [7:0]     ctl;   // {rw, m2r, mw, mr, asrc, br, eq, goto}
        logic [OPW-1:0] alu;
    } rec_t;

    rec_t m_ex;
    int   m_bub;

    function automatic logic [W-1:0] wb_value(input logic [AW-1:0] r, input logic [W-1:0] rf);
        if (wb_reg_write && r != 0 && r == wb_waddr) return wb_wdata;
        return rf;
    endfunction

    // Instruction in ID reads a register that the load in EX has not produced yet.
    function automatic logic m_stall();
        logic reads_rt;
        if (flush) return 1'b0;
        if (!(m_ex.valid && m_ex.ctl[4] && m_ex.wa != 0)) return 1'b0;
        reads_rt = !id_alu_src || id_mem_write || id_branch;
        return (m_ex.wa == id_rs) || (reads_rt && m_ex.wa == id_rt);
    endfunction

    function automatic rec_t m_capture(input logic live);
        rec_t e;
        e.valid = live;
        e.pc  = id_pc;   e.imm = id_imm;
        e.r1  = wb_value(id_rs, id_rdata1);
        e.r2  = wb_value(id_rt, id_rdata2);
        e.rs  = id_rs;   e.rt = id_rt;   e.wa = id_waddr;
        e.alu = id_alu_ctrl;
        e.ctl = live ? {id_reg_write, id_mem_to_reg, id_mem_write, id_mem_read,
                        id_alu_src, id_branch, id_eq, id_goto} : 8'h00;
        return e;
    endfunction

    always @(posedge clock) begin
        if (!reset) begin
            m_ex  <= '0;
            m_bub <= 0;
        end else if (flush) begin
            m_ex  <= m_capture(1'b0);
        end else if (hold_in) begin
            m_ex  <= m_ex;
        end else if (m_stall()) begin
            m_ex  <= m_capture(1'b0);
            m_bub <= (m_bub == 65535) ? m_bub : m_bub + 1;
        end else begin
            m_ex  <= m_capture(1'b1);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Cycle compare against the model, away from the active edge.
    always @(negedge clock) begin
        if (chk_en) begin
            check("m.hazard_stall", hazard_stall, m_stall());
            check("m.ex_valid", ex_valid, m_ex.valid);
            check("m.ctl", {ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_mem_read,
                            ex_alu_src, ex_branch, ex_eq, ex_goto}, m_ex.ctl);
            check("m.bubble_count", bubble_count, m_bub);
            if (m_ex.valid) begin
                check("m.ex_pc", ex_pc, m_ex.pc);
                check("m.ex_rdata1", ex_rdata1, m_ex.r1);
                check("m.ex_rdata2", ex_rdata2, m_ex.r2);
                check("m.ex_imm", ex_imm, m_ex.imm);
                check("m.ex_regs", {ex_rs, ex_rt, ex_waddr}, {m_ex.rs, m_ex.rt, m_ex.wa});
                check("m.ex_alu_ctrl", ex_alu_ctrl, m_ex.alu);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic id_clear();
        id_pc = '0; id_rdata1 = '0; id_rdata2 = '0; id_imm = '0;
        id_rs = '0; id_rt = '0; id_waddr = '0;
        id_reg_write = 0; id_mem_to_reg = 0; id_mem_write = 0; id_mem_read = 0;
        id_alu_src = 0; id_branch = 0; id_eq = 0; id_goto = 0; id_alu_ctrl = '0;
    endtask

    task automatic drive_lw(input logic [W-1:0] pc, input logic [AW-1:0] dst);
        id_clear();
        id_pc = pc; id_rs = 5'd1; id_rt = dst; id_waddr = dst; id_imm = 32'h4;
        id_reg_write = 1; id_mem_to_reg = 1; id_mem_read = 1; id_alu_src = 1;
        id_alu_ctrl = 6'h20;
    endtask

    task automatic drive_rtype(input logic [W-1:0] pc, input logic [AW-1:0] rs,
                               input logic [AW-1:0] rt, input logic [AW-1:0] rd);
        id_clear();
        id_pc = pc; id_rs = rs; id_rt = rt; id_waddr = rd;
        id_rdata1 = 32'h11; id_rdata2 = 32'h22;
        id_reg_write = 1; id_alu_ctrl = 6'h20;
    endtask

    initial begin
        reset = 0; flush = 0; hold_in = 0;
        wb_reg_write = 0; wb_waddr = '0; wb_wdata = '0;
        // Reset with every id_* input at all ones.
        id_pc = '1; id_rdata1 = '1; id_rdata2 = '1; id_imm = '1;
        id_rs = '1; id_rt = '1; id_waddr = '1;
        id_reg_write = 1; id_mem_to_reg = 1; id_mem_write = 1; id_mem_read = 1;
        id_alu_src = 1; id_branch = 1; id_eq = 1; id_goto = 1; id_alu_ctrl = '1;
        step();
        chk_en = 1'b1;
        step();
        check("rst.ex_valid", ex_valid, 0);
        check("rst.ex_pc", ex_pc, 0);
        check("rst.ex_ctl", {ex_reg_write, ex_mem_read, ex_goto, ex_alu_ctrl}, 0);
        check("rst.bubble_count", bubble_count, 0);

        // Normal capture.
        reset = 1;
        id_clear();
        id_pc = 32'h10; id_rdata1 = 5; id_rdata2 = 7; id_reg_write = 1;
        id_alu_ctrl = 6'h20; id_waddr = 3; id_rs = 1; id_rt = 2;
        step();
        check("cap.ex_valid", ex_valid, 1);
        check("cap.ex_pc", ex_pc, 32'h10);
        check("cap.ex_rdata1", ex_rdata1, 5);
        check("cap.ex_rdata2", ex_rdata2, 7);
        check("cap.ex_reg_write", ex_reg_write, 1);
        check("cap.ex_alu_ctrl", ex_alu_ctrl, 6'h20);
        check("cap.ex_waddr", ex_waddr, 3);

        // Load-use on rt: exactly one bubble, then the consumer is captured.
        drive_lw(32'h14, 5'd8);
        step();
        drive_rtype(32'h18, 5'd9, 5'd8, 5'd10);
        #1;
        check("lu.hazard_stall", hazard_stall, 1);
        step();
        check("lu.bubble_valid", ex_valid, 0);
        check("lu.bubble_ctl", {ex_reg_write, ex_mem_to_reg, ex_mem_read}, 0);
        check("lu.bubble_count", bubble_count, 1);
        check("lu.stall_released", hazard_stall, 0);
        step();
        check("lu.consumer_valid", ex_valid, 1);
        check("lu.consumer_pc", ex_pc, 32'h18);
        check("lu.consumer_waddr", ex_waddr, 10);

        // No hazard: load to $0 consumed as $0.
        drive_lw(32'h1c, 5'd0);
        step();
        drive_rtype(32'h20, 5'd0, 5'd0, 5'd11);
        #1;
        check("nh.zero_stall", hazard_stall, 0);
        step();
        check("nh.zero_valid", ex_valid, 1);
        check("nh.zero_bubbles", bubble_count, 1);

        // No hazard: addi whose rt is its destination, not a source.
        drive_lw(32'h24, 5'd8);
        step();
        id_clear();
        id_pc = 32'h28; id_rs = 5'd1; id_rt = 5'd8; id_waddr = 5'd8;
        id_alu_src = 1; id_reg_write = 1; id_imm = 32'h7;
        #1;
        check("nh.addi_stall", hazard_stall, 0);
        step();
        check("nh.addi_valid", ex_valid, 1);
        check("nh.addi_bubbles", bubble_count, 1);

        // Write-back bypass into both operands.
        drive_rtype(32'h2c, 5'd4, 5'd4, 5'd12);
        id_rdata1 = 0; id_rdata2 = 0;
        wb_reg_write = 1; wb_waddr = 5'd4; wb_wdata = 32'hDEAD;
        step();
        check("byp.ex_rdata1", ex_rdata1, 32'hDEAD);
        check("byp.ex_rdata2", ex_rdata2, 32'hDEAD);
        wb_waddr = 5'd0;
        step();
        check("byp0.ex_rdata1", ex_rdata1, 0);
        check("byp0.ex_rdata2", ex_rdata2, 0);
        wb_waddr = 5'd4; id_rt = 5'd5; id_rdata2 = 32'h55;
        step();
        check("byp1.ex_rdata1", ex_rdata1, 32'hDEAD);
        check("byp1.ex_rdata2", ex_rdata2, 32'h55);
        wb_reg_write = 0; wb_waddr = '0; wb_wdata = '0;

        // Flush with hold and a hazard all asserted together.
        drive_lw(32'h30, 5'd8);
        step();
        drive_rtype(32'h34, 5'd9, 5'd8, 5'd13);
        flush = 1; hold_in = 1;
        #1;
        check("fl.hazard_stall", hazard_stall, 0);
        step();
        check("fl.ex_valid", ex_valid, 0);
        check("fl.ex_ctl", {ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_alu_src}, 0);
        check("fl.bubble_count", bubble_count, 1);
        check("fl.ex_pc", ex_pc, 32'h34);
        flush = 0; hold_in = 0;

        // Hold for three edges with changing inputs.
        drive_rtype(32'h40, 5'd2, 5'd3, 5'd14);
        step();
        hold_in = 1;
        for (int i = 0; i < 3; i++) begin
            id_pc = 32'h100 + 32'(i); id_waddr = 5'(20 + i); id_reg_write = 0;
            step();
            check("hold.ex_pc", ex_pc, 32'h40);
            check("hold.ex_waddr", ex_waddr, 14);
            check("hold.ex_valid", ex_valid, 1);
        end
        hold_in = 0;

        // Hold with a load-use pending: stall still shown, bubble only after release.
        drive_lw(32'h44, 5'd8);
        step();
        drive_rtype(32'h48, 5'd8, 5'd2, 5'd15);
        hold_in = 1;
        #1;
        check("hh.hazard_stall", hazard_stall, 1);
        step();
        check("hh.ex_mem_read", ex_mem_read, 1);
        check("hh.bubble_count", bubble_count, 1);
        hold_in = 0;
        step();
        check("hh.bubble_count_after", bubble_count, 2);
        step();
        check("hh.consumer_pc", ex_pc, 32'h48);

        // Reset in the middle of a stall.
        drive_lw(32'h4c, 5'd8);
        step();
        drive_rtype(32'h50, 5'd8, 5'd8, 5'd16);
        reset = 0;
        step();
        check("rs.ex_valid", ex_valid, 0);
        check("rs.bubble_count", bubble_count, 0);
        reset = 1;
        step();
        check("rs.after_valid", ex_valid, 1);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        failed++;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
